dsp_sram_arbiter: RTL and testbench

- Shares the two DSP SRAM banks between two requesters: the core MEM stage (load/store, priority requester) and the receiver sample-ingest path (write-only, buffered).
- Ingest writes are queued in a small FIFO. They drain into a bank only in cycles when the core is not using that bank.
- A starvation guard and an address-hazard check stall the core when needed, so the ingest path always makes progress and stores stay in order.

---
 rtl/dsp_sram_arbiter_pkg.sv | 16 +
 rtl/dsp_sram_arbiter_ingest_fifo.sv | 75 +++++++
 rtl/dsp_sram_arbiter.sv | 124 ++++++++++++
 tb/tb_dsp_sram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_sram_arbiter_pkg.sv
// Shared constants for the DSP SRAM arbiter: address decode, widths and ingest defaults.
package dsp_sram_arbiter_pkg;

    localparam int CORE_ADDR_W          = 16;
    localparam int BANK_SEL_BIT         = 15;
    localparam int SRAM_ADDR_LEN        = 12;
    localparam int REG_WORD_LEN         = 16;
    localparam int STARVE_LIMIT_DEFAULT = 8;
    localparam int INGEST_FIFO_DEPTH    = 4;

    // Bank index of a core/ingest address: 0 = bank1, 1 = bank2.
    function automatic logic bank_of(input logic [CORE_ADDR_W-1:0] addr);
        return addr[BANK_SEL_BIT];
    endfunction

endpackage

// File: rtl/dsp_sram_arbiter_ingest_fifo.sv
// Synchronous ingest write FIFO; exposes every entry address and valid bit so the
// arbiter can detect core accesses that would overtake a queued write.
module dsp_sram_arbiter_ingest_fifo
    import dsp_sram_arbiter_pkg::*;
#(
    parameter  int DEPTH  = INGEST_FIFO_DEPTH,
    parameter  int ADDR_W = SRAM_ADDR_LEN,
    parameter  int DATA_W = REG_WORD_LEN,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic [CORE_ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]                 push_data,
    input  logic                              pop,
    output logic                              full,
    output logic                              empty,
    output logic [LVL_W-1:0]                  level,
    output logic                              head_bank,
    output logic [ADDR_W-1:0]                 head_addr,
    output logic [DATA_W-1:0]                 head_data,
    output logic [DEPTH-1:0][CORE_ADDR_W-1:0] entry_addr,
    output logic [DEPTH-1:0]                  entry_valid
);

    logic [DEPTH-1:0][CORE_ADDR_W-1:0] addr_mem;
    logic [DEPTH-1:0][DATA_W-1:0]      data_mem;
    logic [DEPTH-1:0]                  valid_q;
    logic [PTR_W:0]                    wr_ptr;
    logic [PTR_W:0]                    rd_ptr;
    logic                              do_push;
    logic                              do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_bank   = bank_of(addr_mem[rd_ptr[PTR_W-1:0]]);
    assign head_addr   = addr_mem[rd_ptr[PTR_W-1:0]][ADDR_W-1:0];
    assign head_data   = data_mem[rd_ptr[PTR_W-1:0]];
    assign entry_addr  = addr_mem;
    assign entry_valid = valid_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid_q <= '0;
        end else begin
            if (do_push) begin
                valid_q[wr_ptr[PTR_W-1:0]] <= 1'b1;
                wr_ptr                     <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                valid_q[rd_ptr[PTR_W-1:0]] <= 1'b0;
                rd_ptr                     <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // NOTE: payload storage is not reset; valid_q and the pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr[PTR_W-1:0]] <= push_addr;
            data_mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/dsp_sram_arbiter.sv
// Two-bank DSP SRAM arbiter: core MEM stage has priority, buffered ingest writes
// drain into idle banks, with a starvation guard and a queued-address hazard stall.
module dsp_sram_arbiter
    import dsp_sram_arbiter_pkg::*;
#(
    parameter  int FIFO_DEPTH   = INGEST_FIFO_DEPTH,
    parameter  int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter  int ADDR_W       = SRAM_ADDR_LEN,
    parameter  int DATA_W       = REG_WORD_LEN,
    localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1,
    localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   core_req,
    input  logic                   core_we,
    input  logic [CORE_ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0]      core_wdata,
    output logic [DATA_W-1:0]      core_rdata,
    output logic                   core_stall,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CORE_ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0]      in_data,
    output logic [ADDR_W-1:0]      b1_addr,
    output logic [ADDR_W-1:0]      b2_addr,
    output logic [DATA_W-1:0]      b1_wdata,
    output logic [DATA_W-1:0]      b2_wdata,
    output logic                   b1_we,
    output logic                   b2_we,
    input  logic [DATA_W-1:0]      b1_rdata,
    input  logic [DATA_W-1:0]      b2_rdata,
    output logic [LVL_W-1:0]       fifo_level
);

    logic                                  full;
    logic                                  empty;
    logic                                  head_valid;
    logic                                  head_bank;
    logic [ADDR_W-1:0]                     head_addr;
    logic [DATA_W-1:0]                     head_data;
    logic [FIFO_DEPTH-1:0][CORE_ADDR_W-1:0] entry_addr;
    logic [FIFO_DEPTH-1:0]                 entry_valid;
    logic                                  push;
    logic                                  pop;
    logic                                  core_bank;
    logic                                  hazard;
    logic                                  starved;
    logic [CNT_W-1:0]                      starve_cnt;
    logic [1:0]                            core_gnt;
    logic [1:0]                            ing_gnt;

    // Registered-only path: in_ready never looks at this cycle's grant.
    assign in_ready   = !full && !rst;
    assign push       = in_valid && in_ready;
    assign pop        = |ing_gnt;
    assign head_valid = !empty;
    assign core_bank  = bank_of(core_addr);
    assign starved    = (starve_cnt == CNT_W'(STARVE_LIMIT));

    dsp_sram_arbiter_ingest_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_addr   (in_addr),
        .push_data   (in_data),
        .pop         (pop),
        .full        (full),
        .empty       (empty),
        .level       (fifo_level),
        .head_bank   (head_bank),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .entry_addr  (entry_addr),
        .entry_valid (entry_valid)
    );

    // NOTE: combinational outputs get a default before any condition so no latch is inferred.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i] == core_addr)) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && core_req;
    end

    always_comb begin
        core_gnt = '0;
        ing_gnt  = '0;
        for (int b = 0; b < 2; b++) begin
            if (!rst) begin
                core_gnt[b] = core_req && (core_bank == 1'(b)) && !hazard
                              && !(starved && head_valid && (head_bank == 1'(b)));
                ing_gnt[b]  = head_valid && (head_bank == 1'(b)) && !core_gnt[b];
            end
        end
    end

    assign core_stall = core_req && !rst && !core_gnt[core_bank];
    assign core_rdata = core_bank ? b2_rdata : b1_rdata;

    assign b1_addr  = core_gnt[0] ? core_addr[ADDR_W-1:0] : head_addr;
    assign b1_wdata = core_gnt[0] ? core_wdata : head_data;
    assign b1_we    = core_gnt[0] ? core_we : ing_gnt[0];
    assign b2_addr  = core_gnt[1] ? core_addr[ADDR_W-1:0] : head_addr;
    assign b2_wdata = core_gnt[1] ? core_wdata : head_data;
    assign b2_we    = core_gnt[1] ? core_we : ing_gnt[1];

    // A valid head that is not popped this cycle was blocked by the core.
    always_ff @(posedge clk) begin
        if (rst || !head_valid || pop) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dsp_sram_arbiter.sv
// Bench for dsp_sram_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dsp_sram_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int AW    = 12;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we;
    logic [15:0]   core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          core_stall;
    logic          in_valid, in_ready;
    logic [15:0]   in_addr;
    logic [DW-1:0] in_data;
    logic [AW-1:0] b1_addr, b2_addr;
    logic [DW-1:0] b1_wdata, b2_wdata, b1_rdata, b2_rdata;
    logic          b1_we, b2_we;
    logic [2:0]    fifo_level;

    dsp_sram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .b1_addr    (b1_addr),
        .b2_addr    (b2_addr),
        .b1_wdata   (b1_wdata),
        .b2_wdata   (b2_wdata),
        .b1_we      (b1_we),
        .b2_we      (b2_we),
        .b1_rdata   (b1_rdata),
        .b2_rdata   (b2_rdata),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Bench-owned SRAM banks (written by the DUT) and the model's view of them.
    logic [DW-1:0] sram [2][4096];
    logic [DW-1:0] mmem [2][4096];

    assign b1_rdata = sram[0][b1_addr];
    assign b2_rdata = sram[1][b2_addr];

    always @(posedge clk) begin
        if (b1_we) sram[0][b1_addr] <= b1_wdata;
        if (b2_we) sram[1][b2_addr] <= b2_wdata;
    end

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } ent_t;

    ent_t q[$];
    int   cnt;
    bit   model_init = 1'b0;
    bit   stall_seen = 1'b0;
    bit   ready_seen = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes are a queue, bank contents are arrays.
    always @(negedge clk) begin
        bit          have_head, hb, cb, hz, core_win, ing_win, exp_stall, exp_ready;
        bit          exp_we [2];
        bit          chk_addr [2];
        logic [11:0] exp_addr [2];
        logic [15:0] exp_wd [2];
        if (rst) begin
            if (model_init) check("level_in_rst", 32'(fifo_level), 32'(q.size()));
            check("ready_in_rst", 32'(in_ready), 0);
            check("b1_we_in_rst", 32'(b1_we), 0);
            check("b2_we_in_rst", 32'(b2_we), 0);
            check("stall_in_rst", 32'(core_stall), 0);
            q.delete();
            cnt        = 0;
            model_init = 1'b1;
        end else if (model_init) begin
            have_head = (q.size() > 0);
            hb        = have_head ? q[0].addr[15] : 1'b0;
            cb        = core_addr[15];
            hz        = 1'b0;
            foreach (q[i]) if (core_req && q[i].addr == core_addr) hz = 1'b1;
            core_win  = core_req && !hz && !(cnt == LIMIT && have_head && hb == cb);
            ing_win   = have_head && !(core_win && cb == hb);
            exp_stall = core_req && !core_win;
            exp_ready = (q.size() < DEPTH);
            for (int b = 0; b < 2; b++) begin
                exp_we[b]   = 1'b0;
                chk_addr[b] = 1'b0;
                exp_addr[b] = '0;
                exp_wd[b]   = '0;
                if (core_win && cb == 1'(b)) begin
                    exp_we[b]   = core_we;
                    chk_addr[b] = 1'b1;
                    exp_addr[b] = core_addr[11:0];
                    exp_wd[b]   = core_wdata;
                end else if (ing_win && hb == 1'(b)) begin
                    exp_we[b]   = 1'b1;
                    chk_addr[b] = 1'b1;
                    exp_addr[b] = q[0].addr[11:0];
                    exp_wd[b]   = q[0].data;
                end
            end
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("fifo_level", 32'(fifo_level), 32'(q.size()));
            check("core_stall", 32'(core_stall), 32'(exp_stall));
            check("b1_we", 32'(b1_we), 32'(exp_we[0]));
            check("b2_we", 32'(b2_we), 32'(exp_we[1]));
            if (chk_addr[0]) check("b1_addr", 32'(b1_addr), 32'(exp_addr[0]));
            if (chk_addr[1]) check("b2_addr", 32'(b2_addr), 32'(exp_addr[1]));
            if (exp_we[0]) check("b1_wdata", 32'(b1_wdata), 32'(exp_wd[0]));
            if (exp_we[1]) check("b2_wdata", 32'(b2_wdata), 32'(exp_wd[1]));
            if (core_req && !core_we && !exp_stall)
                check("core_rdata", 32'(core_rdata), 32'(mmem[cb][core_addr[11:0]]));
            for (int b = 0; b < 2; b++) if (exp_we[b]) mmem[b][exp_addr[b]] = exp_wd[b];
            if (!have_head || ing_win) cnt = 0;
            else if (cnt < LIMIT) cnt++;
            if (ing_win) q.delete(0);
            if (in_valid && exp_ready) q.push_back('{addr: in_addr, data: in_data});
        end
        stall_seen = core_stall;
        ready_seen = in_ready;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic core_idle();
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
    endtask

    task automatic rand_phase(input int n);
        for (int c = 0; c < n; c++) begin
            step();
            rst = (c == n / 2);
            if (!stall_seen) begin
                core_req   = ($urandom_range(0, 3) != 0);
                core_we    = $urandom_range(0, 1);
                core_addr  = {1'($urandom_range(0, 1)), 3'b000, 12'($urandom_range(0, 7))};
                core_wdata = 16'($urandom);
            end
            if (!(in_valid && !ready_seen)) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_addr  = {1'($urandom_range(0, 1)), 3'b000, 12'($urandom_range(0, 7))};
                in_data  = 16'($urandom);
            end
        end
    endtask

    initial begin
        bit accepted;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 4096; a++) begin
                sram[b][a] = {4'(b + 1), 12'(a)};
                mmem[b][a] = {4'(b + 1), 12'(a)};
            end

        // Reset held two cycles with traffic offered.
        rst = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0010; core_wdata = '0;
        in_valid = 1'b1; in_addr = 16'h0001; in_data = 16'h1111;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_we", 32'({b1_we, b2_we}), 0);
        @(negedge clk);
        check("rst_level2", 32'(fifo_level), 0);
        step();
        rst = 1'b0; in_valid = 1'b0; core_idle();
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 1);

        // Parallel banks: core reads bank1 while ingest drains into bank2.
        step();
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0010;
        in_valid = 1'b1; in_addr = 16'h8004; in_data = 16'hBEEF;
        @(negedge clk);
        check("par_rdata0", 32'(core_rdata), 32'h1010);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("par_b2_we", 32'(b2_we), 1);
        check("par_b2_addr", 32'(b2_addr), 32'h004);
        check("par_b2_wdata", 32'(b2_wdata), 32'hBEEF);
        check("par_rdata", 32'(core_rdata), 32'h1010);
        check("par_stall", 32'(core_stall), 0);
        step();
        core_idle();

        // Conflict: core stores hog bank2; the queued write is forced through on the ninth cycle.
        for (int k = 0; k <= 10; k++) begin
            step();
            core_req = 1'b1; core_we = 1'b1;
            core_addr = 16'h8000 + 16'((k == 10) ? 9 : k);
            core_wdata = 16'(k);
            in_valid = (k == 0); in_addr = 16'h8020; in_data = 16'hCAFE;
            @(negedge clk);
            check("conf_stall", 32'(core_stall), 32'(k == 9));
            if (k == 9) begin
                check("conf_b2_we", 32'(b2_we), 1);
                check("conf_b2_addr", 32'(b2_addr), 32'h020);
                check("conf_b2_wdata", 32'(b2_wdata), 32'hCAFE);
            end
        end
        step();
        core_idle(); in_valid = 1'b0;

        // Hazard: a load of a queued address waits for the write to land.
        step();
        in_valid = 1'b1; in_addr = 16'h0042; in_data = 16'h1234;
        step();
        in_valid = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0042;
        @(negedge clk);
        check("haz_stall", 32'(core_stall), 1);
        for (int i = 0; i < 4 && core_stall; i++) begin
            step();
            @(negedge clk);
        end
        check("haz_released", 32'(core_stall), 0);
        check("haz_rdata", 32'(core_rdata), 32'h1234);
        step();
        core_idle();

        // Full FIFO: core holds bank2, four writes queue, a fifth waits and is not lost.
        for (int i = 0; i < 4; i++) begin
            step();
            core_req = 1'b1; core_we = 1'b1; core_addr = 16'h8100; core_wdata = 16'h0777;
            in_valid = 1'b1; in_addr = 16'h8010 + 16'(i); in_data = 16'hA000 + 16'(i);
        end
        step();
        in_addr = 16'h8014; in_data = 16'h5555;
        @(negedge clk);
        check("full_level", 32'(fifo_level), 4);
        check("full_ready", 32'(in_ready), 0);
        accepted = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        check("full_accept", 32'(accepted), 1);
        step();
        in_valid = 1'b0; core_idle();
        repeat (8) step();
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h8014;
        @(negedge clk);
        check("full_rdata", 32'(core_rdata), 32'h5555);
        check("full_drained", 32'(fifo_level), 0);
        step();
        core_idle();

        // Wrap: ten interleaved pushes and pops, pointers roll over.
        for (int i = 0; i < 10; i++) begin
            step();
            in_valid = 1'b1;
            in_addr  = {1'(i % 2), 3'b000, 12'(12'h200 + i)};
            in_data  = 16'hD000 + 16'(i);
        end
        step();
        in_valid = 1'b0;
        step();
        @(negedge clk);
        check("wrap_level", 32'(fifo_level), 0);

        rand_phase(3000);
        step();
        rst = 1'b0; in_valid = 1'b0; core_idle();
        repeat (12) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
